// File: rtl/robo_pkg.sv
// Shared types for the pipe-inspection robot controller.
//   state_t   : controller FSM states
//   heading_t : compass heading encoding (bench and motion-driver use)
//   cmd_t     : one-hot command vector {adv, rot, col} and its constants
package robo_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned HDG_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        FOLLOW = 3'd2,
        TURNED = 3'd3,
        REMOVE = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Counter-clockwise rotation walks N -> O -> S -> L -> N.
    typedef enum logic [HDG_W-1:0] {
        HDG_N = 2'b00,
        HDG_S = 2'b01,
        HDG_L = 2'b10,
        HDG_O = 2'b11
    } heading_t;

    typedef struct packed {
        logic adv;
        logic rot;
        logic col;
    } cmd_t;

    localparam cmd_t CMD_NONE = '{adv: 1'b0, rot: 1'b0, col: 1'b0};
    localparam cmd_t CMD_ADV  = '{adv: 1'b1, rot: 1'b0, col: 1'b0};
    localparam cmd_t CMD_ROT  = '{adv: 1'b0, rot: 1'b1, col: 1'b0};
    localparam cmd_t CMD_COL  = '{adv: 1'b0, rot: 1'b0, col: 1'b1};

endpackage

// File: rtl/robo_ctrl.sv
// Left-hand wall-following controller with debris removal.
// Ports:
//   clock            : system clock, rising edge
//   reset            : asynchronous active-low reset
//   head, left       : wall ahead / wall on the left
//   under            : robot is on a black (pipe start/end) cell
//   barrier          : debris directly ahead
//   avancar          : advance one cell (registered)
//   girar            : rotate 90 deg counter-clockwise (registered)
//   recolher_entulho : collect debris ahead (registered)
// At most one command is high per cycle; commands appear one cycle after
// the sensor sample that produced them.
module robo_ctrl
    import robo_pkg::*;
#(
    parameter bit STOP_ON_UNDER = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic avancar,
    output logic girar,
    output logic recolher_entulho
);

    state_t r_state;
    state_t w_state_nxt;
    cmd_t   r_cmd;
    cmd_t   w_cmd_nxt;
    logic   r_moved;
    logic   r_last_adv;

    // State, command and flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cmd      <= CMD_NONE;
            r_moved    <= 1'b0;
            r_last_adv <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_moved    <= r_moved | w_cmd_nxt.adv;
            r_last_adv <= w_cmd_nxt.adv;
        end
    end

    // Next state and next command; within each state the first match wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = CMD_NONE;
        case (r_state)
            IDLE: begin
                w_state_nxt = SEARCH;
            end
            SEARCH: begin
                if (barrier) begin
                    w_cmd_nxt   = CMD_COL;
                    w_state_nxt = REMOVE;
                end else if (head) begin
                    w_cmd_nxt   = CMD_ROT;
                end else if (left) begin
                    w_cmd_nxt   = CMD_ADV;
                    w_state_nxt = FOLLOW;
                end else begin
                    w_cmd_nxt   = CMD_ADV;
                end
            end
            FOLLOW: begin
                if (STOP_ON_UNDER && under && r_moved) begin
                    w_state_nxt = DONE;
                end else if (barrier) begin
                    w_cmd_nxt   = CMD_COL;
                    w_state_nxt = REMOVE;
                end else if (!left && r_last_adv) begin
                    // Left wall vanished right after a step: turn into the opening.
                    w_cmd_nxt   = CMD_ROT;
                    w_state_nxt = TURNED;
                end else if (!head) begin
                    w_cmd_nxt   = CMD_ADV;
                end else begin
                    w_cmd_nxt   = CMD_ROT;
                end
            end
            TURNED: begin
                if (barrier) begin
                    w_cmd_nxt   = CMD_COL;
                    w_state_nxt = REMOVE;
                end else if (!head) begin
                    w_cmd_nxt   = CMD_ADV;
                    w_state_nxt = FOLLOW;
                end else begin
                    w_cmd_nxt   = CMD_ROT;
                    w_state_nxt = FOLLOW;
                end
            end
            REMOVE: begin
                if (barrier) begin
                    w_cmd_nxt   = CMD_COL;
                end else begin
                    w_cmd_nxt   = CMD_ADV;
                    w_state_nxt = FOLLOW;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign avancar          = r_cmd.adv;
    assign girar            = r_cmd.rot;
    assign recolher_entulho = r_cmd.col;

endmodule

// File: tb/tb_robo_ctrl.sv
// Directed bench for robo_ctrl: reset, wall search, wall following,
// debris removal, black-cell stop and asynchronous reset during removal.
module tb_robo_ctrl;

    localparam logic [2:0] O_NONE = 3'b000;
    localparam logic [2:0] O_ADV  = 3'b100;
    localparam logic [2:0] O_ROT  = 3'b010;
    localparam logic [2:0] O_COL  = 3'b001;

    logic clock = 1'b0;
    logic reset;
    logic head, left, under, barrier;
    logic avancar, girar, recolher_entulho;
    logic [2:0] w_out;

    int checks = 0;
    int errors = 0;

    assign w_out = {avancar, girar, recolher_entulho};

    always #5 clock = ~clock;

    robo_ctrl #(.STOP_ON_UNDER(1'b1)) dut (
        .clock            (clock),
        .reset            (reset),
        .head             (head),
        .left             (left),
        .under            (under),
        .barrier          (barrier),
        .avancar          (avancar),
        .girar            (girar),
        .recolher_entulho (recolher_entulho)
    );

    // Sensor vector order: {head, left, under, barrier}
    task automatic set_sensors(input logic [3:0] s);
        {head, left, under, barrier} = s;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] stim [3] = '{4'b1111, 4'b0101, 4'b1010};
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_sensors(stim[i]);
            tick();
            checks++;
            if (w_out !== O_NONE) begin
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, w_out, O_NONE);
                errors++;
            end
        end
        set_sensors(4'b0000);
        release_reset();
        tick();
        checks++;
        if (w_out !== O_NONE) begin
            $display("FAIL idle_to_search: got %b expected %b", w_out, O_NONE);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (w_out !== O_ADV) begin
                $display("FAIL search_open[%0d]: got %b expected %b", i, w_out, O_ADV);
                errors++;
            end
        end
    endtask

    // Starts in SEARCH; ends in FOLLOW after an advance.
    task automatic test_search();
        logic [3:0] stim [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0100};
        logic [2:0] expv [5] = '{O_ROT, O_ROT, O_ROT, O_ADV, O_ADV};
        for (int i = 0; i < 5; i++) begin
            set_sensors(stim[i]);
            tick();
            checks++;
            if (w_out !== expv[i]) begin
                $display("FAIL search[%0d]: got %b expected %b", i, w_out, expv[i]);
                errors++;
            end
        end
    endtask

    // Lost left wall after a step -> one rotate, then advance and keep following.
    task automatic test_follow_lost_wall();
        logic [3:0] stim [5] = '{4'b0000, 4'b0000, 4'b0100, 4'b1100, 4'b0100};
        logic [2:0] expv [5] = '{O_ROT, O_ADV, O_ADV, O_ROT, O_ADV};
        for (int i = 0; i < 5; i++) begin
            set_sensors(stim[i]);
            tick();
            checks++;
            if (w_out !== expv[i]) begin
                $display("FAIL follow_lost_wall[%0d]: got %b expected %b", i, w_out, expv[i]);
                errors++;
            end
        end
    endtask

    // Debris held for six edges (with a wall ahead too: barrier wins).
    task automatic test_barrier();
        set_sensors(4'b1101);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (w_out !== O_COL) begin
                $display("FAIL barrier_hold[%0d]: got %b expected %b", i, w_out, O_COL);
                errors++;
            end
        end
        set_sensors(4'b0100);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (w_out !== O_ADV) begin
                $display("FAIL barrier_clear[%0d]: got %b expected %b", i, w_out, O_ADV);
                errors++;
            end
        end
    endtask

    // Black start cell is ignored; after moving, a black cell halts in DONE.
    task automatic test_under();
        logic [3:0] stim [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110,
                                 4'b1001, 4'b0101, 4'b0000};
        logic [2:0] expv [8] = '{O_NONE, O_ADV, O_ADV, O_ADV, O_NONE,
                                 O_NONE, O_NONE, O_NONE};
        reset = 1'b0;
        set_sensors(4'b0010);
        release_reset();
        for (int i = 0; i < 8; i++) begin
            set_sensors(stim[i]);
            tick();
            checks++;
            if (w_out !== expv[i]) begin
                $display("FAIL under[%0d]: got %b expected %b", i, w_out, expv[i]);
                errors++;
            end
        end
    endtask

    // Reset asserted between edges while collecting clears outputs at once.
    task automatic test_reset_mid_remove();
        reset = 1'b0;
        set_sensors(4'b0000);
        release_reset();
        tick();
        checks++;
        if (w_out !== O_NONE) begin
            $display("FAIL mr_idle: got %b expected %b", w_out, O_NONE);
            errors++;
        end
        set_sensors(4'b1001);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (w_out !== O_COL) begin
                $display("FAIL mr_collect[%0d]: got %b expected %b", i, w_out, O_COL);
                errors++;
            end
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (w_out !== O_NONE) begin
            $display("FAIL mr_async_clear: got %b expected %b", w_out, O_NONE);
            errors++;
        end
        tick();
        checks++;
        if (w_out !== O_NONE) begin
            $display("FAIL mr_held: got %b expected %b", w_out, O_NONE);
            errors++;
        end
        set_sensors(4'b0000);
        release_reset();
        tick();
        checks++;
        if (w_out !== O_NONE) begin
            $display("FAIL mr_restart_idle: got %b expected %b", w_out, O_NONE);
            errors++;
        end
        tick();
        checks++;
        if (w_out !== O_ADV) begin
            $display("FAIL mr_restart_adv: got %b expected %b", w_out, O_ADV);
            errors++;
        end
    endtask

    initial begin
        reset = 1'b0;
        set_sensors(4'b0000);
        test_reset();
        test_search();
        test_follow_lost_wall();
        test_barrier();
        test_under();
        test_reset_mid_remove();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
